// File: rtl/cordic_pkg.sv
// Shared constants (Q16 radians and CORDIC gain), FSM states, fold-correction codes
// and saturation helpers for the CORDIC controller.
package cordic_pkg;

  localparam int PI_Q16      = 205887;
  localparam int HALF_PI_Q16 = 102944;
  localparam int K_Q16       = 39797;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_OUT       = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CORR_NONE   = 2'd0,
    CORR_ADD_PI = 2'd1,
    CORR_SUB_PI = 2'd2
  } corr_e;

  // Clamp v to the range of a w-bit two's-complement number.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] neg_sat(input logic signed [63:0] v, input int w);
    return sat_to(-v, w);
  endfunction

endpackage

// File: rtl/cordic_quad_fold.sv
// Combinational quadrant fold: brings operands into the core's convergence range and
// reports the out_z correction that undoes a vectoring fold.
module cordic_quad_fold
  import cordic_pkg::*;
#(
  parameter int DW = 20
) (
  input  logic                 mode_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] y_i,
  input  logic signed [DW-1:0] z_i,
  output logic signed [DW-1:0] x_o,
  output logic signed [DW-1:0] y_o,
  output logic signed [DW-1:0] z_o,
  output corr_e                corr_o
);

  localparam logic signed [DW:0] PI_W      = (DW+1)'(PI_Q16);
  localparam logic signed [DW:0] HALF_PI_W = (DW+1)'(HALF_PI_Q16);

  logic signed [DW:0]   x_e;
  logic signed [DW:0]   y_e;
  logic signed [DW:0]   z_e;
  logic signed [DW:0]   z_sub;
  logic signed [DW:0]   z_add;
  logic signed [DW-1:0] x_neg;
  logic signed [DW-1:0] y_neg;

  assign x_e   = (DW+1)'(x_i);
  assign y_e   = (DW+1)'(y_i);
  assign z_e   = (DW+1)'(z_i);
  assign z_sub = z_e - PI_W;
  assign z_add = z_e + PI_W;
  // -(most negative) clamps to the most positive value
  assign x_neg = DW'(neg_sat(64'(x_e), DW));
  assign y_neg = DW'(neg_sat(64'(y_e), DW));

  always_comb begin
    x_o    = x_i;
    y_o    = y_i;
    z_o    = z_i;
    corr_o = CORR_NONE;
    if (!mode_i) begin
      if (z_e > HALF_PI_W) begin
        x_o = x_neg;
        y_o = y_neg;
        z_o = DW'(sat_to(64'(z_sub), DW));
      end else if (z_e < -HALF_PI_W) begin
        x_o = x_neg;
        y_o = y_neg;
        z_o = DW'(sat_to(64'(z_add), DW));
      end
    end else if (x_i[DW-1]) begin
      x_o    = x_neg;
      y_o    = y_neg;
      corr_o = y_i[DW-1] ? CORR_SUB_PI : CORR_ADD_PI;
    end
  end

endmodule

// File: rtl/cordic_ctrl.sv
// CORDIC core controller: fold, one-shot start, wait for done, out_z correction, optional gain comp (CORDIC_GAIN_COMP_EN).
// Accept-to-out_valid = core busy time + 3 cycles; one request in flight, out_* held until out_ready.
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int DW = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic signed [DW-1:0] in_x,
  input  logic signed [DW-1:0] in_y,
  input  logic signed [DW-1:0] in_z,
  output logic                 core_start,
  output logic                 core_mode,
  output logic signed [DW-1:0] core_x0,
  output logic signed [DW-1:0] core_y0,
  output logic signed [DW-1:0] core_z0,
  input  logic                 core_busy,
  input  logic signed [DW:0]   core_x,
  input  logic signed [DW:0]   core_y,
  input  logic signed [DW:0]   core_z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW:0]   out_x,
  output logic signed [DW:0]   out_y,
  output logic signed [DW:0]   out_z
);

  localparam logic signed [DW+1:0] PI_W2 = (DW+2)'(PI_Q16);

  state_e               state_q, state_d;
  logic                 in_ready_q, mode_q;
  logic signed [DW-1:0] x0_q, y0_q, z0_q;
  logic signed [DW-1:0] fold_x, fold_y, fold_z;
  corr_e                corr_q, fold_corr;
  logic signed [DW:0]   ox_q, oy_q, oz_q;
  logic signed [DW:0]   gx, gy, gz;
  logic signed [DW+1:0] z_ext, z_corr;
  logic                 accept, capture;

  cordic_quad_fold #(.DW(DW)) u_fold (
    .mode_i (in_mode),
    .x_i    (in_x),
    .y_i    (in_y),
    .z_i    (in_z),
    .x_o    (fold_x),
    .y_o    (fold_y),
    .z_o    (fold_z),
    .corr_o (fold_corr)
  );

  assign accept  = in_valid && in_ready_q;
  // core_busy is high out of reset, so it is only trusted once WAIT_DONE is reached
  assign capture = (state_q == ST_WAIT_DONE) && !core_busy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept) state_d = ST_START;
      ST_START:     state_d = ST_WAIT_ACK;
      ST_WAIT_ACK:  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!core_busy) state_d = ST_OUT;
      ST_OUT:       if (out_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [DW+17:0] K_W   = (DW+18)'(K_Q16);
  localparam logic signed [DW+17:0] RND_W = (DW+18)'(32768);
  logic signed [DW+17:0] px, py, sx, sy;

  assign px = (DW+18)'(core_x) * K_W;
  assign py = (DW+18)'(core_y) * K_W;
  assign sx = (px + RND_W) >>> 16;
  assign sy = (py + RND_W) >>> 16;
  assign gx = (DW+1)'(sat_to(64'(sx), DW+1));
  assign gy = (DW+1)'(sat_to(64'(sy), DW+1));
`else
  assign gx = core_x;
  assign gy = core_y;
`endif

  assign z_ext = (DW+2)'(core_z);
  always_comb begin
    case (corr_q)
      CORR_ADD_PI: z_corr = z_ext + PI_W2;
      CORR_SUB_PI: z_corr = z_ext - PI_W2;
      default:     z_corr = z_ext;
    endcase
  end
  assign gz = (DW+1)'(sat_to(64'(z_corr), DW+1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      mode_q     <= 1'b0;
      x0_q       <= '0;
      y0_q       <= '0;
      z0_q       <= '0;
      corr_q     <= CORR_NONE;
      ox_q       <= '0;
      oy_q       <= '0;
      oz_q       <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_IDLE);
      if (accept) begin
        mode_q <= in_mode;
        x0_q   <= fold_x;
        y0_q   <= fold_y;
        z0_q   <= fold_z;
        corr_q <= fold_corr;
      end
      if (capture) begin
        ox_q <= gx;
        oy_q <= gy;
        oz_q <= gz;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign core_start = (state_q == ST_START);
  assign core_mode  = mode_q;
  assign core_x0    = x0_q;
  assign core_y0    = y0_q;
  assign core_z0    = z0_q;
  assign out_valid  = (state_q == ST_OUT);
  assign out_x      = ox_q;
  assign out_y      = oy_q;
  assign out_z      = oz_q;

endmodule

// File: tb/tb_cordic_ctrl.sv
// Bench for cordic_ctrl: ideal-math core model behind the DUT, scoreboard of expected
// results derived from the unfolded inputs, directed fold/stall/reset scenarios.
module tb_cordic_ctrl;

  localparam int  DW       = 20;
  localparam int  CORE_CYC = 17;
  localparam real G        = 1.646760258;
`ifdef CORDIC_GAIN_COMP_EN
  localparam real    GE  = 1.646760258 * 39797.0 / 65536.0;
  localparam longint TXY = 16;
`else
  localparam real    GE  = 1.646760258;
  localparam longint TXY = 32;
`endif
  localparam longint TZ = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid, in_ready, in_mode;
  logic signed [DW-1:0] in_x, in_y, in_z;
  logic                 core_start, core_mode, core_busy;
  logic signed [DW-1:0] core_x0, core_y0, core_z0;
  logic signed [DW:0]   core_x, core_y, core_z;
  logic                 out_valid, out_ready;
  logic signed [DW:0]   out_x, out_y, out_z;

  typedef struct {
    string  tag;
    longint ex, ey, ez;
    int     acc;
  } exp_t;

  exp_t sb[$];
  bit   seen = 1'b0;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  cordic_ctrl #(.DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_z       (in_z),
    .core_start (core_start),
    .core_mode  (core_mode),
    .core_x0    (core_x0),
    .core_y0    (core_y0),
    .core_z0    (core_z0),
    .core_busy  (core_busy),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_z     (core_z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_z      (out_z)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint want, input longint tol = 0);
    longint d;
    chk_cnt++;
    d = obs - want;
    if (d < 0) d = -d;
    if (d <= tol) pass_cnt++;
    else $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, want, tol);
  endtask

  // Ideal CORDIC result (sel 0/1/2 = x/y/z) in Q16, with gain g applied to x/y.
  function automatic longint ideal(input int sel, input bit m, input real x, input real y,
                                   input real z, input real g);
    real t, r;
    t = z / 65536.0;
    r = 0.0;
    if (!m) begin
      if (sel == 0) r = g * (x * $cos(t) - y * $sin(t));
      else if (sel == 1) r = g * (y * $cos(t) + x * $sin(t));
    end else begin
      if (sel == 0) r = g * $sqrt(x * x + y * y);
      else if (sel == 2) r = z + $atan2(y, x) * 65536.0;
    end
    return longint'(r);
  endfunction

  // Core model: busy from reset; results appear and busy falls CORE_CYC cycles
  // after the core's first working cycle.
  int     ccnt;
  bit     cm;
  longint lx, ly, lz;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_busy <= 1'b1;
      ccnt      <= 0;
      core_x    <= '0;
      core_y    <= '0;
      core_z    <= '0;
    end else if (core_start) begin
      lx        <= core_x0;
      ly        <= core_y0;
      lz        <= core_z0;
      cm        <= core_mode;
      ccnt      <= CORE_CYC + 1;
      core_busy <= 1'b1;
    end else if (ccnt != 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) begin
        core_busy <= 1'b0;
        core_x    <= (DW+1)'(ideal(0, cm, lx, ly, lz, G));
        core_y    <= (DW+1)'(ideal(1, cm, lx, ly, lz, G));
        core_z    <= (DW+1)'(ideal(2, cm, lx, ly, lz, G));
      end
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset && out_valid) begin
      if (sb.size() == 0) begin
        if (!seen) check("spurious_out_valid", 1, 0);
        seen = !out_ready;
      end else begin
        if (!seen) begin
          check({sb[0].tag, "_latency"}, cyc - sb[0].acc, CORE_CYC + 3);
          seen = 1'b1;
        end
        if (out_ready) begin
          e = sb.pop_front();
          check({e.tag, "_out_x"}, out_x, e.ex, TXY);
          check({e.tag, "_out_y"}, out_y, e.ey, TXY);
          check({e.tag, "_out_z"}, out_z, e.ez, TZ);
          seen = 1'b0;
        end
      end
    end
  end

  task automatic run_op(input string tag, input bit m, input longint x, input longint y,
                        input longint z, input longint ex0, input longint ey0, input longint ez0);
    int   n;
    exp_t e;
    @(negedge clk);
    in_mode  = m;
    in_x     = DW'(x);
    in_y     = DW'(y);
    in_z     = DW'(z);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.tag = tag;
    e.ex  = ideal(0, m, x, y, z, GE);
    e.ey  = ideal(1, m, x, y, z, GE);
    e.ez  = ideal(2, m, x, y, z, GE);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    check({tag, "_start"}, core_start, 1);
    check({tag, "_mode"}, core_mode, m);
    check({tag, "_x0"}, core_x0, ex0);
    check({tag, "_y0"}, core_y0, ey0);
    check({tag, "_z0"}, core_z0, ez0);
    @(negedge clk);
    check({tag, "_start_1cyc"}, core_start, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, changes;
    logic signed [DW:0] first_x;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_z      = '0;
    out_ready = 1'b1;
    #22;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_x0", core_x0, 0);
    check("rst_out_x", out_x, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);

    run_op("rot_pi",    0,   65536,      0,  205887,   65536 * -1,      0,      0); wait_done();
    run_op("rot_negz",  0,       0,  65536, -150000,        0,   -65536,  55887); wait_done();
    run_op("rot_pass",  0,   40000, -20000,   30000,    40000,   -20000,  30000); wait_done();
    run_op("vec_fold",  1,  -65536,      0,       0,    65536,        0,      0); wait_done();
    run_op("vec_negy",  1,  -65536,     -1,       0,    65536,        1,      0); wait_done();
    run_op("vec_pass",  1,   30000,  40000,       0,    30000,    40000,      0); wait_done();
    run_op("sat_neg",   0, -524288,      0,  205887,   524287,        0,      0); wait_done();

    // Result held while out_ready is low
    out_ready = 1'b0;
    run_op("stall", 0, 50000, 10000, 0, 50000, 10000, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid", out_valid, 1);
    first_x = out_x;
    changes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_no_start", core_start, 0);
      if (out_x != first_x) changes++;
    end
    check("stall_out_x_stable", changes, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    wait_done();

    // Reset in WAIT_DONE drops the in-flight request
    run_op("rst_mid", 1, -65536, 0, 0, 65536, 0, 0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    sb.delete();
    seen = 1'b0;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_core_start", core_start, 0);
    check("mid_rst_core_mode", core_mode, 0);
    check("mid_rst_core_x0", core_x0, 0);
    check("mid_rst_core_y0", core_y0, 0);
    check("mid_rst_core_z0", core_z0, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_x", out_x, 0);
    check("mid_rst_out_y", out_y, 0);
    check("mid_rst_out_z", out_z, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_hold_valid", out_valid, 0);
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rel_in_ready", in_ready, 1);
    run_op("after_rst", 0, 20000, 30000, -40000, 20000, 30000, -40000);
    wait_done();
    repeat (30) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cordic_ctrl.md
CORDIC_CTRL -- requirements
Module: cordic_ctrl

Interface
REQ-001 The module SHALL have parameter DW, default 20, the input operand width; result width is DW+1.
REQ-002 The module SHALL have these ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- in_mode  in  1  0 = rotation, 1 = vectoring; drives the core's calc_mode
- in_x, in_y, in_z  in  DW each  signed, Q3.16; angles in radians
- core_start  out  1  start pulse to the CORDIC core
- core_mode  out  1  mode to the core
- core_x0, core_y0, core_z0  out  DW each  folded operands to the core
- core_busy  in  1  core busy flag
- core_x, core_y, core_z  in  DW+1 each  core results
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_x, out_y, out_z  out  DW+1 each  signed, quadrant-corrected results

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, START, WAIT_ACK, WAIT_DONE and OUT.
REQ-004 in_ready SHALL be 1 only in IDLE.
REQ-005 On the in handshake, the block SHALL register the mode and the folded operands, record the fold flag and correction, and go to START.
REQ-006 Rotation fold SHALL work as follows:
- z > HALF_PI: core operands are -x, -y, z-PI.
- z < -HALF_PI: core operands are -x, -y, z+PI.
- Otherwise operands pass unchanged.
- No output correction is applied.
REQ-007 Vectoring fold SHALL work as follows:
- x < 0: core operands are -x, -y, z, and the fold is flagged.
- Flag with y >= 0: add PI to out_z.
- Flag with y < 0: subtract PI from out_z.
REQ-008 Negation SHALL saturate: -(-2^(DW-1)) gives 2^(DW-1)-1.
REQ-009 Fold adds and subtracts SHALL be computed in DW+1 bits, then saturated to DW bits.
REQ-010 In START, core_start SHALL be 1 for exactly one cycle; the next state is WAIT_ACK.
REQ-011 core_x0/y0/z0 and core_mode SHALL hold stable from START until the next accept.
REQ-012 WAIT_ACK SHALL last exactly one cycle and then go to WAIT_DONE; core_busy SHALL be ignored in START and WAIT_ACK, because the core's busy flag is 1 out of reset.
REQ-013 In WAIT_DONE, the first cycle with core_busy==0 SHALL capture core_x/y/z, apply correction and gain compensation (see Configuration), register out_*, and go to OUT.
REQ-014 In OUT, out_valid SHALL be 1 and out_* SHALL be stable until out_ready.
REQ-015 On the out handshake, the FSM SHALL go to IDLE; in_ready rises the following cycle, with no same-cycle accept.
REQ-016 Latency SHALL be accept-to-out_valid = core busy time + 3 cycles; with a 16-iteration core this is 20 cycles.
REQ-017 out_z correction SHALL be computed in DW+2 bits and saturated to DW+1 bits.
REQ-018 in_valid while not in IDLE SHALL be ignored; the upstream holds the request.

Reset
REQ-019 Assertion of reset (low) SHALL immediately set:
- state to IDLE
- in_ready = 0
- core_start = 0, core_mode = 0
- core_x0/y0/z0 = 0
- out_valid = 0, out_x/y/z = 0
- internal flags = 0
REQ-020 The cycle after deassertion, in_ready SHALL be 1.
REQ-021 Reset mid-operation SHALL discard the in-flight request with no out_valid for it.

Configuration
REQ-022 With CORDIC_GAIN_COMP_EN defined:
- out_x and out_y SHALL equal core result × K_Q16 (39797), arithmetic-shifted right by 16 with round-half-up.
- The product is DW+18 bits wide, then saturated to DW+1 bits.
- Latency is unchanged (single-cycle multiply).
REQ-023 Without CORDIC_GAIN_COMP_EN, out_x and out_y SHALL be the raw core results, and no multiplier SHALL be instantiated.
- out_z is never gain-compensated.

Structure
REQ-024 Package cordic_pkg SHALL hold:
- PI_Q16 = 205887, HALF_PI_Q16 = 102944, K_Q16 = 39797
- the FSM state enum
- the saturate helper functions
REQ-025 Sub-module cordic_quad_fold (combinational) SHALL implement REQ-006..REQ-009 and output the folded operands plus the correction code.
- The FSM, registers and gain multiply stay in cordic_ctrl.

Verification
REQ-026 The bench SHALL use a core model with busy=1 from reset, pulling busy low 17 cycles after start.
REQ-027 The bench SHALL cover these directed scenarios:
- Rotation, x=65536, y=0, z=205887 (pi), GAIN_COMP on: core gets x0=-65536, z0=0; out_x=-65536±16, out_y=0±16.
- Vectoring, x=-65536, y=0, GAIN_COMP off: out_x=107925±32 (1.6468×65536), out_z=205887±8.
- Vectoring, x=-65536, y=-1: out_z=-205887±8.
- Result with out_ready held 0 for 10 cycles: out_* stable, in_ready=0, no second core_start; on release, in_ready=1 the next cycle.
- reset pulsed low during WAIT_DONE: all outputs 0 immediately, no out_valid, new request accepted the cycle after release.
- in_x=-524288: saturating negate gives core_x0=524287.
